// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic stage registers: occupancy states,
// occupancy width and default payload/control widths per pipeline boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam int OCC_W = 2;

    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 96;
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_DATA_W = 64;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 64;
    localparam int MEMWB_CTRL_W = 8;

    function automatic logic [OCC_W-1:0] occ_of(input stage_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One held beat (payload and control packed together) with load, synchronous
// clear and asynchronous reset; clear wins over load.
module pipe_stage_entry #(
    parameter int W = 112
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic stage register between two pipeline stages: valid/ready handshake,
// optional 2-entry skid buffer, and flush that turns every held entry into a bubble.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int ENT_W = DATA_W + CTRL_W;

    stage_state_e     state_q, state_d;
    logic             in_fire, out_fire;
    logic             mainLoad, mainClear, skidLoad, skidClear;
    logic [ENT_W-1:0] main_d, main_q, skid_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Ready comes from the state register alone, cutting the out_ready path.
            assign in_ready = (state_q != ST_TWO);

            pipe_stage_entry #(.W(ENT_W)) u_skid (
                .clk     (CLK),
                .rst     (RST),
                .load_i  (skidLoad),
                .clear_i (skidClear),
                .d_i     ({in_ctrl, in_data}),
                .q_o     (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
            assign skid_q   = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        main_d    = {in_ctrl, in_data};
        if (FLUSH) begin
            state_d   = ST_EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d  = ST_ONE;
                        mainLoad = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        mainLoad = 1'b1;
                    end else if (in_fire) begin
                        state_d  = ST_TWO;
                        skidLoad = 1'b1;
                    end else if (out_fire) begin
                        state_d   = ST_EMPTY;
                        mainClear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d   = ST_ONE;
                        main_d    = skid_q;
                        mainLoad  = 1'b1;
                        skidClear = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_stage_entry #(.W(ENT_W)) u_main (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (mainLoad),
        .clear_i (mainClear),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    assign {out_ctrl, out_data} = out_valid ? main_q : '0;
    assign occupancy            = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a skid and a no-skid instance with identical stimulus; each is checked
// against its own queue model (capacity 2 and 1) by a negedge monitor.
module tb_pipe_stage_buf;

    localparam int DW = 96;
    localparam int CW = 16;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          FLUSH    = 1'b0;
    logic          inValid  = 1'b0;
    logic          outReady = 1'b0;
    logic [DW-1:0] inData   = '0;
    logic [CW-1:0] inCtrl   = '0;

    logic          inReadyS, outValidS, inReadyN, outValidN;
    logic [DW-1:0] outDataS, outDataN;
    logic [CW-1:0] outCtrlS, outCtrlN;
    logic [1:0]    occS, occN;

    beat_t qS[$];
    beat_t qN[$];
    beat_t headS, headN;
    int    checks = 0;
    int    errors = 0;
    bit    monEn  = 1'b0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dutSkid (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .in_valid(inValid), .in_ready(inReadyS), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValidS), .out_ready(outReady), .out_data(outDataS), .out_ctrl(outCtrlS),
        .occupancy(occS)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dutNoSkid (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .in_valid(inValid), .in_ready(inReadyN), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValidN), .out_ready(outReady), .out_data(outDataN), .out_ctrl(outCtrlN),
        .occupancy(occN)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; the model queues are updated at
    // the following edge so the monitor always sees the state the DUT holds.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input bit ordy, input bit fl);
        bit    fireS, fireN;
        beat_t b;
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        outReady = ordy;
        FLUSH    = fl;
        fireS    = v && (qS.size() < 2);
        fireN    = v && ((qN.size() == 0) || ordy);
        b.c      = c;
        b.d      = d;
        @(posedge CLK);
        if (fl) begin
            qS.delete();
            qN.delete();
        end else begin
            if (fireS) qS.push_back(b);
            if (fireN) qN.push_back(b);
        end
        #1;
    endtask

    task automatic sendDirected(input int val, input bit ordy, input bit fl);
        applyStimulus(1'b1, DW'(val), CW'(val) | 16'h5A00, ordy, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic checkResetState();
        checkOutput("rst.skid.out_valid", 128'(outValidS), 128'(0));
        checkOutput("rst.skid.out_data",  128'(outDataS),  128'(0));
        checkOutput("rst.skid.out_ctrl",  128'(outCtrlS),  128'(0));
        checkOutput("rst.skid.occupancy", 128'(occS),      128'(0));
        checkOutput("rst.skid.in_ready",  128'(inReadyS),  128'(1));
        checkOutput("rst.noskid.out_valid", 128'(outValidN), 128'(0));
        checkOutput("rst.noskid.out_data",  128'(outDataN),  128'(0));
        checkOutput("rst.noskid.occupancy", 128'(occN),      128'(0));
    endtask

    // Compares every visible output with the model head, then retires the head
    // when the model says the downstream side takes it this cycle.
    always @(negedge CLK) begin
        if (monEn) begin
            headS = (qS.size() > 0) ? qS[0] : '0;
            headN = (qN.size() > 0) ? qN[0] : '0;
            checkOutput("skid.out_valid", 128'(outValidS), 128'(qS.size() > 0));
            checkOutput("skid.out_data",  128'(outDataS),  128'(headS.d));
            checkOutput("skid.out_ctrl",  128'(outCtrlS),  128'(headS.c));
            checkOutput("skid.occupancy", 128'(occS),      128'(qS.size()));
            checkOutput("skid.in_ready",  128'(inReadyS),  128'(qS.size() < 2));
            checkOutput("noskid.out_valid", 128'(outValidN), 128'(qN.size() > 0));
            checkOutput("noskid.out_data",  128'(outDataN),  128'(headN.d));
            checkOutput("noskid.out_ctrl",  128'(outCtrlN),  128'(headN.c));
            checkOutput("noskid.occupancy", 128'(occN),      128'(qN.size()));
            checkOutput("noskid.in_ready",  128'(inReadyN),
                        128'((qN.size() == 0) || (outReady == 1'b1)));
            if (qS.size() > 0 && outReady) void'(qS.pop_front());
            if (qN.size() > 0 && outReady) void'(qN.pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        checkResetState();
        RST   = 1'b0;
        monEn = 1'b1;

        for (int i = 1; i <= 8; i++) sendDirected(i, 1'b1, 1'b0);
        idle(3);

        sendDirected(32'hA, 1'b0, 1'b0);
        sendDirected(32'hB, 1'b0, 1'b0);
        sendDirected(32'hC, 1'b0, 1'b0);
        sendDirected(32'hC, 1'b1, 1'b0);
        idle(4);

        sendDirected(32'hA, 1'b0, 1'b0);
        sendDirected(32'hB, 1'b0, 1'b0);
        sendDirected(32'hC, 1'b1, 1'b1);
        idle(3);

        for (int k = 0; k < 8; k++) sendDirected(32'h20 + k, (k % 2) == 0, 1'b0);
        idle(3);

        sendDirected(32'h31, 1'b0, 1'b0);
        sendDirected(32'h32, 1'b0, 1'b0);
        inValid = 1'b0;
        RST     = 1'b1;
        qS.delete();
        qN.delete();
        #1;
        checkResetState();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
                          CW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
